// File: rtl/matmul_pkg.sv
// Shared widths and state encoding for the matrix-multiply scheduler.
package matmul_pkg;
    localparam int MAX_ELEMENT_SIZE = 8;
    localparam int MAX_ROW_SIZE_A   = 32;
    localparam int MAX_INNER_SIZE   = 32;
    localparam int MAX_COL_SIZE_B   = 32;

    localparam int RES_W   = 2 * MAX_ELEMENT_SIZE + $clog2(MAX_INNER_SIZE);
    localparam int IDX_A_W = $clog2(MAX_ROW_SIZE_A);
    localparam int IDX_B_W = $clog2(MAX_COL_SIZE_B);
    localparam int DIM_A_W = $clog2(MAX_ROW_SIZE_A + 1);
    localparam int DIM_B_W = $clog2(MAX_COL_SIZE_B + 1);
    localparam int VEC_W   = MAX_INNER_SIZE * MAX_ELEMENT_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_A,
        FETCH_B,
        ISSUE,
        WAIT_RES,
        OUT,
        DONE
    } sched_state_t;
endpackage

// File: rtl/matmul_scheduler_if.sv
// Control, fetch, dot-product and result signals of the scheduler.
// master = scheduler side, slave = compiler / dot-product / packer side.
interface matmul_scheduler_if;
    import matmul_pkg::*;

    logic               start;
    logic               abort;
    logic [DIM_A_W-1:0] rows_a;
    logic [DIM_B_W-1:0] cols_b;

    logic               a_req;
    logic [IDX_A_W-1:0] a_idx;
    logic               a_ack;
    logic [VEC_W-1:0]   a_row_in;

    logic               b_req;
    logic [IDX_B_W-1:0] b_idx;
    logic               b_ack;
    logic [VEC_W-1:0]   b_col_in;

    logic               dp_valid;
    logic               dp_ready;
    logic [VEC_W-1:0]   dp_a;
    logic [VEC_W-1:0]   dp_b;
    logic               dp_res_valid;
    logic [RES_W-1:0]   dp_res;

    logic               res_valid;
    logic               res_ready;
    logic [RES_W-1:0]   res_data;
    logic [IDX_A_W-1:0] res_i;
    logic [IDX_B_W-1:0] res_j;

    logic               busy;
    logic               done;
    logic               err;

    modport master (
        input  start, abort, rows_a, cols_b,
        input  a_ack, a_row_in, b_ack, b_col_in,
        input  dp_ready, dp_res_valid, dp_res, res_ready,
        output a_req, a_idx, b_req, b_idx,
        output dp_valid, dp_a, dp_b,
        output res_valid, res_data, res_i, res_j,
        output busy, done, err
    );

    modport slave (
        output start, abort, rows_a, cols_b,
        output a_ack, a_row_in, b_ack, b_col_in,
        output dp_ready, dp_res_valid, dp_res, res_ready,
        input  a_req, a_idx, b_req, b_idx,
        input  dp_valid, dp_a, dp_b,
        input  res_valid, res_data, res_i, res_j,
        input  busy, done, err
    );
endinterface

// File: rtl/matmul_idx_counter.sv
// Nested row-major (i, j) counter; j is the inner index, both wrap to 0 after the last element.
// Latency: flags are combinational from the registered indices. No backpressure: advance_i is a strobe.
module matmul_idx_counter
    import matmul_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clear_i,
    input  logic               advance_i,
    input  logic [IDX_A_W-1:0] rows_m1_i,
    input  logic [IDX_B_W-1:0] cols_m1_i,
    output logic [IDX_A_W-1:0] i_o,
    output logic [IDX_B_W-1:0] j_o,
    output logic               last_row_o,
    output logic               last_col_o
);
    logic [IDX_A_W-1:0] i_q;
    logic [IDX_B_W-1:0] j_q;

    assign i_o        = i_q;
    assign j_o        = j_q;
    assign last_row_o = (i_q == rows_m1_i);
    assign last_col_o = (j_q == cols_m1_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            i_q <= '0;
            j_q <= '0;
        end else if (clear_i) begin
            i_q <= '0;
            j_q <= '0;
        end else if (advance_i) begin
            if (last_col_o) begin
                j_q <= '0;
                i_q <= last_row_o ? '0 : i_q + 1'b1;
            end else begin
                j_q <= j_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/matmul_scheduler.sv
// Sequences C = A x B: fetch A row once per i, B column per (i, j), issue to the dot-product unit, stream C row-major.
// Latency: 4 cycles per result with same-cycle handshakes, +1 per new row. Every handshake stage holds its outputs until accepted.
module matmul_scheduler
    import matmul_pkg::*;
(
    input  logic inter_refclk,
    input  logic inter_rst_n,
    matmul_scheduler_if.master bus
);
    sched_state_t       state_q;
    logic [IDX_A_W-1:0] rows_m1_q;
    logic [IDX_B_W-1:0] cols_m1_q;
    logic               a_req_q, b_req_q, dp_valid_q, res_valid_q;
    logic               busy_q, done_q, err_q;
    logic [VEC_W-1:0]   dp_a_q, dp_b_q;
    logic [RES_W-1:0]   res_data_q;

    logic [IDX_A_W-1:0] i_cnt;
    logic [IDX_B_W-1:0] j_cnt;
    logic               last_row, last_col;
    logic               dims_zero, dims_big, start_run, adv;

    assign dims_zero = (bus.rows_a == '0) || (bus.cols_b == '0);
    assign dims_big  = (bus.rows_a > DIM_A_W'(MAX_ROW_SIZE_A)) ||
                       (bus.cols_b > DIM_B_W'(MAX_COL_SIZE_B));
    assign start_run = (state_q == IDLE) && bus.start && !dims_zero && !dims_big;
    assign adv       = (state_q == OUT) && bus.res_ready && !bus.abort;

    matmul_idx_counter u_idx (
        .clk_i      (inter_refclk),
        .rst_n_i    (inter_rst_n),
        .clear_i    (start_run),
        .advance_i  (adv),
        .rows_m1_i  (rows_m1_q),
        .cols_m1_i  (cols_m1_q),
        .i_o        (i_cnt),
        .j_o        (j_cnt),
        .last_row_o (last_row),
        .last_col_o (last_col)
    );

    always_ff @(posedge inter_refclk or negedge inter_rst_n) begin
        if (!inter_rst_n) begin
            state_q     <= IDLE;
            rows_m1_q   <= '0;
            cols_m1_q   <= '0;
            a_req_q     <= 1'b0;
            b_req_q     <= 1'b0;
            dp_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            res_data_q  <= '0;
        end else begin
            done_q <= 1'b0;
            // Abort beats every other transition, including a same-cycle ack.
            if (state_q != IDLE && bus.abort) begin
                state_q     <= IDLE;
                a_req_q     <= 1'b0;
                b_req_q     <= 1'b0;
                dp_valid_q  <= 1'b0;
                res_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            if (dims_zero) begin
                                err_q   <= 1'b0;
                                busy_q  <= 1'b1;
                                state_q <= DONE;
                            end else if (dims_big) begin
                                err_q <= 1'b1;
                            end else begin
                                rows_m1_q <= IDX_A_W'(bus.rows_a - 1'b1);
                                cols_m1_q <= IDX_B_W'(bus.cols_b - 1'b1);
                                err_q     <= 1'b0;
                                busy_q    <= 1'b1;
                                a_req_q   <= 1'b1;
                                state_q   <= FETCH_A;
                            end
                        end
                    end
                    FETCH_A: begin
                        if (bus.a_ack) begin
                            dp_a_q  <= bus.a_row_in;
                            a_req_q <= 1'b0;
                            b_req_q <= 1'b1;
                            state_q <= FETCH_B;
                        end
                    end
                    FETCH_B: begin
                        if (bus.b_ack) begin
                            dp_b_q     <= bus.b_col_in;
                            b_req_q    <= 1'b0;
                            dp_valid_q <= 1'b1;
                            state_q    <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (bus.dp_ready) begin
                            dp_valid_q <= 1'b0;
                            state_q    <= WAIT_RES;
                        end
                    end
                    WAIT_RES: begin
                        if (bus.dp_res_valid) begin
                            res_data_q  <= bus.dp_res;
                            res_valid_q <= 1'b1;
                            state_q     <= OUT;
                        end
                    end
                    OUT: begin
                        if (bus.res_ready) begin
                            res_valid_q <= 1'b0;
                            if (!last_col) begin
                                b_req_q <= 1'b1;
                                state_q <= FETCH_B;
                            end else if (!last_row) begin
                                a_req_q <= 1'b1;
                                state_q <= FETCH_A;
                            end else begin
                                state_q <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Indices come straight from the counter; it only moves on the result handshake.
    assign bus.a_req     = a_req_q;
    assign bus.a_idx     = i_cnt;
    assign bus.b_req     = b_req_q;
    assign bus.b_idx     = j_cnt;
    assign bus.dp_valid  = dp_valid_q;
    assign bus.dp_a      = dp_a_q;
    assign bus.dp_b      = dp_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_i     = i_cnt;
    assign bus.res_j     = j_cnt;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler with a responder process and a result scoreboard.
module tb_matmul_scheduler;
    import matmul_pkg::*;

    typedef struct {
        int unsigned i;
        int unsigned j;
        int unsigned data;
    } exp_t;

    logic clk;
    logic rst_n;
    matmul_scheduler_if mif();

    matmul_scheduler dut (
        .inter_refclk (clk),
        .inter_rst_n  (rst_n),
        .bus          (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   a_en = 1, b_en = 1, rdy_en = 1;
    int   dp_off = 0;
    int   a_hs = 0, b_hs = 0, n_res = 0, done_cnt = 0;
    int   a_seen = 0, b_seen = 0, rv_seen = 0;
    bit   dp_pend = 0;
    logic [RES_W-1:0] dp_val = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input int rows, input int cols);
        for (int i = 0; i < rows; i++)
            for (int j = 0; j < cols; j++)
                sb.push_back('{i: i, j: j, data: i * 10 + j + dp_off});
    endtask

    task automatic pulse_start(input int rows, input int cols);
        mif.rows_a = DIM_A_W'(rows);
        mif.cols_b = DIM_B_W'(cols);
        mif.start  = 1'b1;
        @(negedge clk);
        mif.start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        int k = 0;
        while (!mif.done && k < lim) begin
            @(negedge clk);
            k++;
        end
        check(tag, 64'(mif.done), 64'd1);
    endtask

    task automatic clear_counts();
        a_hs = 0; b_hs = 0; n_res = 0; done_cnt = 0;
        a_seen = 0; b_seen = 0; rv_seen = 0;
    endtask

    initial begin
        exp_t e;
        int   k;
        mif.start = 0; mif.abort = 0; mif.rows_a = '0; mif.cols_b = '0;
        mif.a_ack = 0; mif.a_row_in = '0; mif.b_ack = 0; mif.b_col_in = '0;
        mif.dp_ready = 0; mif.dp_res_valid = 0; mif.dp_res = '0; mif.res_ready = 0;
        rst_n = 1'b0;

        // Environment: same-cycle acks, dot-product result one cycle after issue.
        fork
            forever begin
                @(negedge clk);
                mif.a_row_in = {{31{8'hA5}}, 3'b000, mif.a_idx};
                mif.b_col_in = {{31{8'h3C}}, 3'b000, mif.b_idx};
                mif.a_ack    = mif.a_req && a_en;
                mif.b_ack    = mif.b_req && b_en;
                mif.dp_ready = 1'b1;
                mif.dp_res_valid = dp_pend;
                mif.dp_res       = dp_val;
                dp_pend = mif.dp_valid && mif.dp_ready;
                dp_val  = RES_W'(int'(mif.dp_a[7:0]) * 10 + int'(mif.dp_b[7:0]) + dp_off);
                mif.res_ready = rdy_en;
                if (rst_n) begin
                    if (mif.a_req) a_seen++;
                    if (mif.b_req) b_seen++;
                    if (mif.res_valid) rv_seen++;
                    if (mif.a_req && mif.a_ack) a_hs++;
                    if (mif.b_req && mif.b_ack) b_hs++;
                    if (mif.done) done_cnt++;
                    if (mif.res_valid && mif.res_ready) begin
                        n_res++;
                        check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            check("res_i", 64'(mif.res_i), 64'(e.i));
                            check("res_j", 64'(mif.res_j), 64'(e.j));
                            check("res_data", 64'(mif.res_data), 64'(e.data));
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(mif.busy), 0);
        check("rst_done", 64'(mif.done), 0);
        check("rst_err", 64'(mif.err), 0);
        check("rst_a_req", 64'(mif.a_req), 0);
        check("rst_b_req", 64'(mif.b_req), 0);
        check("rst_dp_valid", 64'(mif.dp_valid), 0);
        check("rst_res_valid", 64'(mif.res_valid), 0);
        check("rst_res_data", 64'(mif.res_data), 0);
        check("rst_dp_a_zero", 64'(mif.dp_a != '0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 2x3 run; a start with other dims mid-run must be ignored
        clear_counts();
        dp_off = 0;
        push_run(2, 3);
        pulse_start(2, 3);
        check("t1_busy", 64'(mif.busy), 1);
        repeat (3) @(negedge clk);
        pulse_start(3, 3);
        wait_done("t1_done", 200);
        check("t1_busy_fall", 64'(mif.busy), 0);
        repeat (3) @(negedge clk);
        check("t1_a_hs", 64'(a_hs), 2);
        check("t1_b_hs", 64'(b_hs), 6);
        check("t1_nres", 64'(n_res), 6);
        check("t1_done_cnt", 64'(done_cnt), 1);
        check("t1_sb_empty", 64'(sb.size()), 0);

        // Zero-row start completes with no traffic
        clear_counts();
        pulse_start(0, 4);
        check("t2_done_c1", 64'(mif.done), 0);
        @(negedge clk);
        check("t2_done_c2", 64'(mif.done), 1);
        check("t2_busy_c2", 64'(mif.busy), 0);
        @(negedge clk);
        check("t2_done_c3", 64'(mif.done), 0);
        repeat (2) @(negedge clk);
        check("t2_a_seen", 64'(a_seen), 0);
        check("t2_b_seen", 64'(b_seen), 0);
        check("t2_rv_seen", 64'(rv_seen), 0);
        check("t2_done_cnt", 64'(done_cnt), 1);

        // 1x2 run with the first result held by downstream
        clear_counts();
        dp_off = 7;
        rdy_en = 0;
        push_run(1, 2);
        pulse_start(1, 2);
        k = 0;
        while (!mif.res_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        for (int c = 0; c < 5; c++) begin
            check("t3_hold_valid", 64'(mif.res_valid), 1);
            check("t3_hold_data", 64'(mif.res_data), 7);
            check("t3_hold_i", 64'(mif.res_i), 0);
            check("t3_hold_j", 64'(mif.res_j), 0);
            check("t3_no_b_req", 64'(mif.b_req), 0);
            @(negedge clk);
        end
        check("t3_b_hs_held", 64'(b_hs), 1);
        rdy_en = 1;
        wait_done("t3_done", 100);
        repeat (2) @(negedge clk);
        check("t3_b_hs", 64'(b_hs), 2);
        check("t3_sb_empty", 64'(sb.size()), 0);

        // 3x3 run aborted while waiting on the (1,1) result
        clear_counts();
        push_run(1, 3);
        sb.push_back('{i: 1, j: 0, data: 10 + dp_off});
        pulse_start(3, 3);
        k = 0;
        while (!(mif.dp_valid && mif.dp_a[7:0] == 8'd1 && mif.dp_b[7:0] == 8'd1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t4_reach_11", 64'(mif.dp_valid), 1);
        @(negedge clk);
        mif.abort = 1'b1;
        @(negedge clk);
        mif.abort = 1'b0;
        check("t4_busy", 64'(mif.busy), 0);
        check("t4_res_valid", 64'(mif.res_valid), 0);
        check("t4_a_req", 64'(mif.a_req), 0);
        check("t4_b_req", 64'(mif.b_req), 0);
        check("t4_dp_valid", 64'(mif.dp_valid), 0);
        check("t4_done", 64'(mif.done), 0);
        repeat (5) @(negedge clk);
        check("t4_no_done", 64'(done_cnt), 0);
        check("t4_nres", 64'(n_res), 4);
        check("t4_sb_empty", 64'(sb.size()), 0);
        push_run(1, 1);
        pulse_start(1, 1);
        wait_done("t4_rerun_done", 100);
        repeat (2) @(negedge clk);
        check("t4_rerun_sb", 64'(sb.size()), 0);

        // Oversize dims set a sticky err that the next accepted start clears
        pulse_start(33, 2);
        check("t5_err", 64'(mif.err), 1);
        check("t5_busy", 64'(mif.busy), 0);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", 64'(mif.err), 1);
        check("t5_no_req", 64'(mif.a_req), 0);
        push_run(1, 1);
        pulse_start(1, 1);
        check("t5_err_clr", 64'(mif.err), 0);
        check("t5_busy_run", 64'(mif.busy), 1);
        wait_done("t5_done", 100);
        repeat (2) @(negedge clk);
        check("t5_sb_empty", 64'(sb.size()), 0);

        // Asynchronous reset while stalled in FETCH_B, then a clean rerun
        b_en = 0;
        pulse_start(2, 2);
        k = 0;
        while (!mif.b_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t6_in_fetch_b", 64'(mif.b_req), 1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_b_req", 64'(mif.b_req), 0);
        check("t6_busy", 64'(mif.busy), 0);
        check("t6_dp_a", 64'(mif.dp_a != '0), 0);
        check("t6_a_req", 64'(mif.a_req), 0);
        check("t6_err", 64'(mif.err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b_en  = 1;
        repeat (2) @(negedge clk);
        check("t6_idle_busy", 64'(mif.busy), 0);
        check("t6_idle_req", 64'(mif.a_req | mif.b_req), 0);
        clear_counts();
        push_run(2, 2);
        pulse_start(2, 2);
        wait_done("t6_done", 200);
        repeat (2) @(negedge clk);
        check("t6_a_hs", 64'(a_hs), 2);
        check("t6_b_hs", 64'(b_hs), 4);
        check("t6_nres", 64'(n_res), 4);
        check("t6_sb_empty", 64'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
